// File: rtl/patlog_pkg.sv
// patlog_pkg: shared defaults, timestamp type and saturating-increment helper
package patlog_pkg;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DEPTH = 8;
  typedef logic [DEF_TS_W-1:0] ts_t;
  // holds at the w-bit all-ones value instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF >> (32 - w);
    return (v == m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/patlog_fifo.sv
// patlog_fifo: synchronous first-word-fall-through FIFO with registered storage
module patlog_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign empty = level_q == '0;
  assign full = level_q == (AW+1)'(DEPTH);
  assign dout = mem_q[rd_q];
  assign level = level_q;
  // a full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage and pointer registers; storage cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/pattern_event_logger.sv
// pattern_event_logger: timestamps and buffers recognizer matches; drop counter gated by PATLOG_DROP_COUNT_EN
module pattern_event_logger
  import patlog_pkg::*;
#(
  parameter int TS_W = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   y,
  input  logic                   en,
  output logic [TS_W-1:0]        ts_data,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);
  logic [TS_W-1:0] ts_q, ts_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic overflow_q, overflow_d;
  logic ev, drop, full, empty;
  // event qualification, free-running timestamp, match counter and sticky overflow
  always_comb begin
    ev = y && en;
    drop = ev && full && !(ts_ready && !empty);
    ts_d = ts_q + 1'b1;
    match_cnt_d = ev ? CNT_W'(sat_inc(32'(match_cnt_q), CNT_W)) : match_cnt_q;
    overflow_d = overflow_q | drop;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
      match_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q <= ts_d;
      match_cnt_q <= match_cnt_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef PATLOG_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  // saturating count of discarded events
  always_comb drop_cnt_d = drop ? CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W)) : drop_cnt_q;
  // drop counter register
  always_ff @(posedge clk) drop_cnt_q <= reset ? '0 : drop_cnt_d;
  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
  patlog_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(ev),
    .din(ts_q),
    .pop(ts_ready),
    .dout(ts_data),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign ts_valid = !empty;
  assign match_cnt = match_cnt_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_pattern_event_logger.sv
// tb_pattern_event_logger: directed plus random stimulus against a queue-based reference model
module tb_pattern_event_logger;
  localparam int TSW = 4;
  localparam int CW = 4;
  localparam int D = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset = 0, y = 0, en = 0, ts_ready = 0;
  logic [TSW-1:0] ts_data;
  logic ts_valid, overflow;
  logic [$clog2(D):0] fifo_level;
  logic [CW-1:0] match_cnt, drop_cnt;
  int nvec = 0, nerr = 0;
  int q[$];
  int cyc = 0, mcnt = 0, dcnt = 0;
  bit ovf = 0;

  pattern_event_logger #(.TS_W(TSW), .CNT_W(CW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .y(y), .en(en),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .fifo_level(fifo_level), .match_cnt(match_cnt),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit yy, input bit ee, input bit rd);
    bit pop, was_full;
    int exp_drop;
    reset = r; y = yy; en = ee; ts_ready = rd;
    if (r) begin
      q.delete(); cyc = 0; mcnt = 0; dcnt = 0; ovf = 0;
    end else begin
      was_full = q.size() == D;
      pop = q.size() > 0 && rd;
      if (pop) void'(q.pop_front());
      if (yy && ee) begin
        if (mcnt < CMAX) mcnt++;
        if (!was_full || pop) q.push_back(cyc % (1 << TSW));
        else begin
          ovf = 1;
          if (dcnt < CMAX) dcnt++;
        end
      end
      cyc++;
    end
    @(posedge clk);
    #1;
`ifdef PATLOG_DROP_COUNT_EN
    exp_drop = dcnt;
`else
    exp_drop = 0;
`endif
    chk("valid", 32'(ts_valid), 32'(q.size() > 0));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("match_cnt", 32'(match_cnt), 32'(mcnt));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    if (q.size() > 0) chk("ts_data", 32'(ts_data), 32'(q[0]));
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_data", 32'(ts_data), 0);
    chk("rst_valid", 32'(ts_valid), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    step(0, 1, 1, 0);
    chk("first_data", 32'(ts_data), 0);
    chk("first_level", 32'(fifo_level), 1);
    chk("first_cnt", 32'(match_cnt), 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("idle_valid", 32'(ts_valid), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    chk("567_head", 32'(ts_data), 5);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    chk("567_cnt", 32'(match_cnt), 3);
    chk("567_level", 32'(fifo_level), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
    chk("full_level", 32'(fifo_level), 8);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_cnt", 32'(match_cnt), 10);
`ifdef PATLOG_DROP_COUNT_EN
    chk("full_drop", 32'(drop_cnt), 2);
`else
    chk("full_drop", 32'(drop_cnt), 0);
`endif
    step(0, 1, 1, 1);
    chk("pushpop_level", 32'(fifo_level), 8);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("en0_level", 32'(fifo_level), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("wrap_data", 32'(ts_data), 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("midrst_valid", 32'(ts_valid), 0);
    chk("midrst_cnt", 32'(match_cnt), 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1);
    chk("sat_cnt", 32'(match_cnt), CMAX);
    step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 60) == 0, 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pattern_event_logger.md
# pattern_event_logger

Downstream consumer of the Moore pattern recognizer's match output `y`. It counts match cycles, timestamps each match with a free-running cycle counter, and buffers the timestamps in a small FIFO. Software or a bench drains the FIFO through a valid/ready port. It is the observation stage behind the recognizer: a bench or top level reads match history from here instead of sampling `y` every cycle.

## Interface
- `TS_W`, 16: timestamp (cycle counter) width.
- `CNT_W`, 16: width of `match_cnt` and `drop_cnt`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `y` in 1: match output from the recognizer. Each cycle sampled high is one match.
- `en` in 1: logging enable. When low, `y` is ignored.
- `ts_data` out TS_W: timestamp at FIFO head.
- `ts_valid` out 1: FIFO non-empty.
- `ts_ready` in 1: consumer accepts head when `ts_valid` is high.
- `fifo_level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `match_cnt` out CNT_W: total matches logged or dropped; saturating.
- `overflow` out 1: sticky; set when any match is dropped.
- `drop_cnt` out CNT_W: number of dropped matches; saturating.

## Operation
- Cycle counter `ts`:
  - 0 at the first rising edge with `reset` low; increments each cycle.
  - Wraps from 2^TS_W−1 to 0.
- Event: `y && en` sampled at a rising edge. The value captured is the `ts` of that same edge.
- Consecutive high cycles of `y`, as with overlapping patterns, are separate events.
- Every event increments `match_cnt`, which holds at all-ones once reached.
- Push: the event writes `ts` to the FIFO tail when `fifo_level < DEPTH`, or when a pop happens in the same cycle.
- Drop: the event is discarded when the FIFO is full and there is no pop that cycle.
  - On a drop, `overflow` is set to 1 and `drop_cnt` increments (saturating).
- Pop: `ts_valid && ts_ready` at an edge advances the head.
- Push and pop in the same cycle:
  - `fifo_level` is unchanged.
  - Data order is preserved.
  - When the FIFO is full, this case is not a drop.
- Empty FIFO: `ts_ready` has no effect. A push into an empty FIFO is not visible at the head until the next cycle.
- `overflow` is cleared only by `reset`.
- Reset asserted mid-operation: on the next edge all state is cleared and FIFO contents are discarded. An event sampled on that same edge is lost.

## Timing
- Reset values:
  - `ts_data`, `ts_valid`, `fifo_level`, `match_cnt`, `overflow`, `drop_cnt` are all 0.
  - The internal `ts` is 0.
- Latency: event at edge N gives `ts_valid` = 1, `ts_data` = captured ts, and updated `fifo_level`/`match_cnt` after edge N. There is no combinational path from `y` to any output.
- `ts_data` is the registered head. It is stable while `ts_valid && !ts_ready`.
- Throughput: one event and one pop per cycle.

## Configuration
- `PATLOG_DROP_COUNT_EN`
  - Defined: `drop_cnt` counts dropped events as above.
  - Undefined: the `drop_cnt` port remains, driven constant 0, and its counter logic is removed. `overflow` behaves identically in both builds.

## Structure
- Package `patlog_pkg`:
  - default `TS_W`/`CNT_W`/`DEPTH` localparams;
  - `typedef logic [TS_W-1:0] ts_t`;
  - a saturating-increment function shared by both counters.
- Sub-module `patlog_fifo`: synchronous, first-word-fall-through, registered head.
  - Parameters: width and depth.
  - Ports: push/din, pop/dout, `full`, `empty`, `level`.
- The top level holds `ts`, event qualification, counters and `overflow`.

## Test plan
- Reset held 2 cycles → all outputs 0. After release with no `y`, outputs stay 0.
- `en`=1, `y` pulse on the first post-reset edge, `ts_ready`=0 → `ts_valid`=1, `ts_data`=0, `fifo_level`=1, `match_cnt`=1.
- `y` high at ts 5,6,7, then `ts_ready`=1 → pops 5,6,7 in order; `match_cnt`=3; `fifo_level` returns to 0.
- DEPTH=8, 10 events at ts 0..9, `ts_ready`=0 →
  - `fifo_level`=8, `overflow`=1, `match_cnt`=10;
  - `drop_cnt`=2 with the macro, 0 without;
  - draining yields 0..7.
- FIFO full, event and pop on the same edge → event accepted, `fifo_level` stays 8, `drop_cnt` unchanged, new ts appears last.
- Edge cases:
  - `en`=0 with `y`=1 → no counters or FIFO change.
  - TS_W=4, event at cycle 17 → `ts_data`=1.
  - `reset` asserted with 3 entries queued → next cycle `ts_valid`=0 and `match_cnt`=0.
